// File: rtl/commit_tracer.sv
// Retirement tracer: captures writeback records, delays them DELAY cycles,
// buffers them in a DEPTH-entry FIFO and keeps instret/skip/cycle counters.
module commit_tracer #(
   parameter int XLEN  = 64,
   parameter int ILEN  = 32,
   parameter int DEPTH = 4,
   parameter int DELAY = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wb_valid,
   input  logic [XLEN-1:0]          wb_pc,
   input  logic [ILEN-1:0]          wb_instr,
   input  logic                     wb_we,
   input  logic [4:0]               wb_rdaddr,
   input  logic [XLEN-1:0]          wb_rd,
   input  logic                     wb_skip,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [XLEN-1:0]          out_pc,
   output logic [ILEN-1:0]          out_instr,
   output logic                     out_we,
   output logic [4:0]               out_rdaddr,
   output logic [XLEN-1:0]          out_rd,
   output logic                     out_skip,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic [63:0]              instret,
   output logic [63:0]              skipcnt,
   output logic [63:0]              cycles
);
   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
      logic            we;
      logic [4:0]      rdaddr;
      logic [XLEN-1:0] rd;
      logic            skip;
   } rec_t;

   rec_t cap_rec;
   rec_t enq_rec;
   rec_t head;
   logic enq_v;

   // Writes to x0 are architecturally invisible, so they are never reported.
   always_comb begin
      cap_rec.pc     = wb_pc;
      cap_rec.instr  = wb_instr;
      cap_rec.we     = wb_we & (wb_rdaddr != 5'd0);
      cap_rec.rdaddr = wb_rdaddr;
      cap_rec.rd     = wb_rd;
      cap_rec.skip   = wb_skip;
   end

   generate
      if (DELAY == 1) begin : g_direct
         assign enq_v   = wb_valid;
         assign enq_rec = cap_rec;
      end else begin : g_stages
         logic stg_v   [DELAY-1];
         rec_t stg_rec [DELAY-1];

         // Free-running shift line, no backpressure; only valid bits reset.
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < DELAY-1; i++) stg_v[i] <= 1'b0;
            end else begin
               stg_v[0] <= wb_valid;
               for (int i = 1; i < DELAY-1; i++) stg_v[i] <= stg_v[i-1];
            end
            stg_rec[0] <= cap_rec;
            for (int i = 1; i < DELAY-1; i++) stg_rec[i] <= stg_rec[i-1];
         end

         assign enq_v   = stg_v[DELAY-2];
         assign enq_rec = stg_rec[DELAY-2];
      end
   endgenerate

   rec_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;
   logic          full;
   logic          pop;
   logic          push;

   // A pop in the same cycle frees a slot, so a full FIFO still accepts.
   assign full = (cnt == (AW+1)'(DEPTH));
   assign pop  = (cnt != '0) && out_ready;
   assign push = enq_v && (!full || pop);

   always_ff @(posedge clk) begin
      if (!rst && push) mem[wr_ptr] <= enq_rec;
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         cnt      <= '0;
         overflow <= 1'b0;
         instret  <= '0;
         skipcnt  <= '0;
         cycles   <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      cnt <= cnt + (AW+1)'(1);
         else if (pop && !push) cnt <= cnt - (AW+1)'(1);
         if (enq_v && !push) overflow <= 1'b1;
         if (pop) begin
            instret <= instret + 64'd1;
            if (head.skip) skipcnt <= skipcnt + 64'd1;
         end
         cycles <= cycles + 64'd1;
      end
   end

   assign head       = mem[rd_ptr];
   assign out_valid  = (cnt != '0);
   assign out_pc     = head.pc;
   assign out_instr  = head.instr;
   assign out_we     = head.we;
   assign out_rdaddr = head.rdaddr;
   assign out_rd     = head.rd;
   assign out_skip   = head.skip;
   assign count      = cnt;

endmodule

// File: tb/tb_commit_tracer.sv
// Bench for commit_tracer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_commit_tracer;
   localparam int XLEN  = 64;
   localparam int ILEN  = 32;
   localparam int DEPTH = 4;
   localparam int DELAY = 2;
   localparam int CW    = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
      logic            we;
      logic [4:0]      rdaddr;
      logic [XLEN-1:0] rd;
      logic            skip;
   } rec_t;
   localparam int REC_W = $bits(rec_t);

   logic            clk = 1'b0;
   logic            rst;
   logic            wb_valid;
   logic [XLEN-1:0] wb_pc;
   logic [ILEN-1:0] wb_instr;
   logic            wb_we;
   logic [4:0]      wb_rdaddr;
   logic [XLEN-1:0] wb_rd;
   logic            wb_skip;
   logic            out_ready;
   logic            out_valid;
   logic [XLEN-1:0] out_pc;
   logic [ILEN-1:0] out_instr;
   logic            out_we;
   logic [4:0]      out_rdaddr;
   logic [XLEN-1:0] out_rd;
   logic            out_skip;
   logic [CW-1:0]   count;
   logic            overflow;
   logic [63:0]     instret;
   logic [63:0]     skipcnt;
   logic [63:0]     cycles;

   commit_tracer #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .DELAY(DELAY)) dut (
      .clk(clk), .rst(rst),
      .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_instr(wb_instr), .wb_we(wb_we),
      .wb_rdaddr(wb_rdaddr), .wb_rd(wb_rd), .wb_skip(wb_skip),
      .out_ready(out_ready), .out_valid(out_valid), .out_pc(out_pc),
      .out_instr(out_instr), .out_we(out_we), .out_rdaddr(out_rdaddr),
      .out_rd(out_rd), .out_skip(out_skip), .count(count),
      .overflow(overflow), .instret(instret), .skipcnt(skipcnt), .cycles(cycles)
   );

   // clock/reset block
   always #5 clk = ~clk;

   // scoreboard state: expected FIFO contents plus records still in the delay line
   logic [REC_W-1:0] exp_q[$];
   logic [REC_W-1:0] pipe_rec[$];
   int               pipe_due[$];
   logic             m_ovf;
   logic [63:0]      m_instret, m_skip, m_cycles;
   int               cyc = 0;
   int               checks = 0;
   int               errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // Next state from the rules: pop head if ready, capture enters the line with
   // a due cycle, due record joins the FIFO if there is room after the pop.
   task automatic model_step();
      rec_t r;
      if (rst) begin
         exp_q.delete(); pipe_rec.delete(); pipe_due.delete();
         m_ovf = 1'b0; m_instret = '0; m_skip = '0; m_cycles = '0;
         return;
      end
      if (exp_q.size() > 0 && out_ready) begin
         r = rec_t'(exp_q.pop_front());
         m_instret++;
         if (r.skip) m_skip++;
      end
      if (wb_valid) begin
         r.pc = wb_pc; r.instr = wb_instr; r.we = wb_we && (wb_rdaddr != 5'd0);
         r.rdaddr = wb_rdaddr; r.rd = wb_rd; r.skip = wb_skip;
         pipe_rec.push_back(REC_W'(r));
         pipe_due.push_back(cyc + DELAY - 1);
      end
      while (pipe_due.size() > 0 && pipe_due[0] == cyc) begin
         void'(pipe_due.pop_front());
         if (exp_q.size() < DEPTH) exp_q.push_back(pipe_rec.pop_front());
         else begin
            void'(pipe_rec.pop_front());
            m_ovf = 1'b1;
         end
      end
      m_cycles++;
   endtask

   task automatic compare();
      rec_t h;
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      chk("count", 64'(count), 64'(exp_q.size()));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("instret", instret, m_instret);
      chk("skipcnt", skipcnt, m_skip);
      chk("cycles", cycles, m_cycles);
      if (exp_q.size() != 0) begin
         h = rec_t'(exp_q[0]);
         chk("out_pc", out_pc, h.pc);
         chk("out_instr", 64'(out_instr), 64'(h.instr));
         chk("out_we", 64'(out_we), 64'(h.we));
         chk("out_rdaddr", 64'(out_rdaddr), 64'(h.rdaddr));
         chk("out_rd", out_rd, h.rd);
         chk("out_skip", 64'(out_skip), 64'(h.skip));
      end
   endtask

   // driver tasks
   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
      compare();
   endtask

   task automatic drive_wb(input logic [63:0] pc, input logic we, input logic [4:0] rdaddr,
                           input logic [63:0] rd, input logic skip);
      wb_valid  = 1'b1;
      wb_pc     = pc;
      wb_instr  = $urandom;
      wb_we     = we;
      wb_rdaddr = rdaddr;
      wb_rd     = rd;
      wb_skip   = skip;
   endtask

   initial begin
      logic [63:0] exp_pcs[4];
      rst = 1'b1; wb_valid = 1'b0; wb_pc = '0; wb_instr = '0; wb_we = 1'b0;
      wb_rdaddr = '0; wb_rd = '0; wb_skip = 1'b0; out_ready = 1'b1;
      tick(); tick();
      rst = 1'b0;

      // reset then idle
      repeat (10) tick();
      chk("idle_cycles", cycles, 64'd10);
      chk("idle_valid", 64'(out_valid), 64'd0);
      chk("idle_count", 64'(count), 64'd0);
      chk("idle_instret", instret, 64'd0);
      chk("idle_overflow", 64'(overflow), 64'd0);

      // single record, two-cycle latency
      drive_wb(64'h8000_0000, 1'b1, 5'd1, 64'd10, 1'b0);
      wb_instr = 32'h00a0_0093;
      tick();
      wb_valid = 1'b0;
      chk("single_t1_valid", 64'(out_valid), 64'd0);
      tick();
      chk("single_valid", 64'(out_valid), 64'd1);
      chk("single_pc", out_pc, 64'h8000_0000);
      chk("single_instr", 64'(out_instr), 64'h00a0_0093);
      chk("single_we", 64'(out_we), 64'd1);
      chk("single_rdaddr", 64'(out_rdaddr), 64'd1);
      chk("single_rd", out_rd, 64'd10);
      tick();
      chk("single_after_valid", 64'(out_valid), 64'd0);
      chk("single_instret", instret, 64'd1);

      // x0 write suppressed, skip counted
      drive_wb(64'h8000_0004, 1'b1, 5'd0, 64'h55, 1'b1);
      tick();
      wb_valid = 1'b0;
      tick();
      chk("x0_we", 64'(out_we), 64'd0);
      chk("skip_flag", 64'(out_skip), 64'd1);
      tick();
      chk("skipcnt_inc", skipcnt, 64'd1);
      chk("instret_2", instret, 64'd2);

      // fill, then push and pop together while full
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_wb(64'h1000 + 64'(i), 1'b1, 5'(i + 1), 64'(i), 1'b0);
         tick();
      end
      wb_valid = 1'b0;
      tick();
      chk("full_count", 64'(count), 64'd4);
      chk("full_overflow", 64'(overflow), 64'd0);
      drive_wb(64'h2000, 1'b1, 5'd7, 64'd7, 1'b0);
      tick();
      wb_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("pushpop_count", 64'(count), 64'd4);
      chk("pushpop_overflow", 64'(overflow), 64'd0);
      exp_pcs[0] = 64'h1001; exp_pcs[1] = 64'h1002; exp_pcs[2] = 64'h1003; exp_pcs[3] = 64'h2000;
      for (int i = 0; i < 4; i++) begin
         chk("pushpop_order", out_pc, exp_pcs[i]);
         tick();
      end
      chk("pushpop_instret", instret, 64'd7);
      chk("pushpop_empty", 64'(count), 64'd0);

      // overflow: fifth record while full and stalled
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive_wb(64'h3000 + 64'(i), 1'b0, 5'd0, 64'd0, 1'b0);
         tick();
      end
      wb_valid = 1'b0;
      tick();
      chk("ovf_flag", 64'(overflow), 64'd1);
      chk("ovf_count", 64'(count), 64'd4);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("ovf_order", out_pc, 64'h3000 + 64'(i));
         tick();
      end
      chk("ovf_instret", instret, 64'd11);
      chk("ovf_sticky", 64'(overflow), 64'd1);

      // reset with records buffered and one in flight
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_wb(64'h4000 + 64'(i), 1'b1, 5'd3, 64'd9, 1'b1);
         tick();
      end
      wb_valid = 1'b0;
      chk("prerst_count", 64'(count), 64'd3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_instret", instret, 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      repeat (5) tick();
      chk("rst_inflight_gone", 64'(count), 64'd0);
      chk("rst_no_pop", instret, 64'd0);

      // randomized traffic with occasional stalls and resets
      for (int n = 0; n < 3000; n++) begin
         wb_valid  = ($urandom_range(0, 9) < 7);
         wb_pc     = {$urandom, $urandom};
         wb_instr  = $urandom;
         wb_we     = $urandom_range(0, 1) == 1;
         wb_rdaddr = 5'($urandom_range(0, 31));
         wb_rd     = {$urandom, $urandom};
         wb_skip   = ($urandom_range(0, 3) == 0);
         out_ready = ((n / 64) % 4 == 3) ? ($urandom_range(0, 9) == 0)
                                         : ($urandom_range(0, 9) < 6);
         rst       = ($urandom_range(0, 399) == 0);
         tick();
      end
      rst = 1'b0;
      wb_valid = 1'b0;
      out_ready = 1'b1;
      repeat (DEPTH + DELAY + 2) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
